// File: rtl/bus_xfer_seq.sv
// Bus transfer sequencer: drives one one-hot source enable, pulses one destination
// enable while the source is still on the bus, then captures the bus value.
module bus_xfer_seq #(
    parameter int NSRC   = 25,
    parameter int NDST   = 24,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_src,
    input  logic [4:0]      req_dst,
    input  logic [31:0]     bus_in,
    output logic [NSRC-1:0] src_out,
    output logic [NDST-1:0] dst_in,
    output logic [31:0]     xfer_data,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);
    localparam logic [4:0]    NO_DST   = 5'h1F;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [4:0]    src_q, dst_q;
    logic          err_q;
    logic          accept, req_bad;

    assign accept  = req_valid && req_ready;
    assign req_bad = ({1'b0, req_src} >= 6'(NSRC)) ||
                     (({1'b0, req_dst} >= 6'(NDST)) && (req_dst != NO_DST));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            err_q     <= 1'b0;
            xfer_data <= 32'h0;
        end else begin
            if (accept) begin
                src_q <= req_src;
                dst_q <= req_dst;
                err_q <= req_bad;
                cnt   <= CNT_INIT;
            end else if (state == DRIVE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == CAPTURE) xfer_data <= bus_in;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = req_bad ? DONE : DRIVE;
            DRIVE:   if (cnt == '0) state_nx = CAPTURE;
            CAPTURE: state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are decoded only from registered state, so they cannot glitch.
    always_comb begin
        req_ready = 1'b0;
        src_out   = '0;
        dst_in    = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            DRIVE:   src_out = NSRC'(1) << src_q;
            CAPTURE: begin
                src_out = NSRC'(1) << src_q;
                if (dst_q != NO_DST) dst_in = NDST'(1) << dst_q;
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq: one instance at SETTLE=1, one at SETTLE=3,
// sharing clock, reset, codes and bus value but with separate request strobes.
module tb_bus_xfer_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid, req_valid3;
    logic [4:0]  req_src, req_dst;
    logic [31:0] bus_in;

    logic        req_ready, done, err;
    logic [24:0] src_out;
    logic [23:0] dst_in;
    logic [31:0] xfer_data;

    logic        req_ready3, done3, err3;
    logic [24:0] src_out3;
    logic [23:0] dst_in3;
    logic [31:0] xfer_data3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_xfer_seq u1 (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .bus_in(bus_in),
        .src_out(src_out), .dst_in(dst_in), .xfer_data(xfer_data),
        .done(done), .err(err)
    );

    bus_xfer_seq #(.SETTLE(3)) u3 (
        .clk(clk), .clr(clr), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_src(req_src), .req_dst(req_dst), .bus_in(bus_in),
        .src_out(src_out3), .dst_in(dst_in3), .xfer_data(xfer_data3),
        .done(done3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Strobe invariants on both instances every cycle.
    always @(negedge clk) begin
        check("inv_src_onehot",  32'($countones(src_out) <= 1), 32'd1);
        check("inv_dst_onehot",  32'($countones(dst_in) <= 1), 32'd1);
        check("inv_dst_has_src", 32'((dst_in == '0) || (src_out != '0)), 32'd1);
        check("inv3_src_onehot", 32'($countones(src_out3) <= 1), 32'd1);
        check("inv3_dst_has_src", 32'((dst_in3 == '0) || (src_out3 != '0)), 32'd1);
    end

    initial begin
        // Reset for two edges with a request pending.
        clr = 1'b1; req_valid = 1'b1; req_valid3 = 1'b1;
        req_src = 5'd20; req_dst = 5'd3; bus_in = 32'h0;
        repeat (2) @(posedge clk);
        tick();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_src",   32'(src_out), 32'h0);
        check("rst_dst",   32'(dst_in), 32'h0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_xfer",  xfer_data, 32'h0);
        check("rst_ready3", 32'(req_ready3), 32'd1);
        clr = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0;

        // Basic transfer PC -> R3.
        tick();
        req_valid = 1'b1; req_src = 5'd20; req_dst = 5'd3; bus_in = 32'h0000_1234;
        tick();
        req_valid = 1'b0;
        check("b1_src",   32'(src_out), 32'h0010_0000);
        check("b1_dst",   32'(dst_in), 32'h0);
        check("b1_ready", 32'(req_ready), 32'd0);
        check("b1_done",  32'(done), 32'd0);
        tick();
        check("b2_src",   32'(src_out), 32'h0010_0000);
        check("b2_dst",   32'(dst_in), 32'h0000_0008);
        check("b2_done",  32'(done), 32'd0);
        tick();
        check("b3_done",  32'(done), 32'd1);
        check("b3_err",   32'(err), 32'd0);
        check("b3_src",   32'(src_out), 32'h0);
        check("b3_dst",   32'(dst_in), 32'h0);
        check("b3_ready", 32'(req_ready), 32'd0);
        check("b3_xfer",  xfer_data, 32'h0000_1234);
        tick();
        check("b4_ready", 32'(req_ready), 32'd1);
        check("b4_done",  32'(done), 32'd0);

        // SETTLE = 3, C drive-only.
        req_valid3 = 1'b1; req_src = 5'd24; req_dst = 5'h1F; bus_in = 32'hCAFE_BABE;
        for (int c = 1; c <= 4; c++) begin
            tick();
            req_valid3 = 1'b0;
            check($sformatf("s3_src_c%0d", c),  32'(src_out3), 32'h0100_0000);
            check($sformatf("s3_dst_c%0d", c),  32'(dst_in3), 32'h0);
            check($sformatf("s3_done_c%0d", c), 32'(done3), 32'd0);
        end
        tick();
        check("s3_done", 32'(done3), 32'd1);
        check("s3_err",  32'(err3), 32'd0);
        check("s3_src_off", 32'(src_out3), 32'h0);
        check("s3_xfer", xfer_data3, 32'hCAFE_BABE);
        tick();
        check("s3_ready", 32'(req_ready3), 32'd1);

        // Invalid source code.
        req_valid = 1'b1; req_src = 5'd25; req_dst = 5'd3;
        tick();
        req_valid = 1'b0;
        check("isrc_done",  32'(done), 32'd1);
        check("isrc_err",   32'(err), 32'd1);
        check("isrc_src",   32'(src_out), 32'h0);
        check("isrc_dst",   32'(dst_in), 32'h0);
        check("isrc_ready", 32'(req_ready), 32'd0);
        tick();
        check("isrc_ready2", 32'(req_ready), 32'd1);
        check("isrc_err2",   32'(err), 32'd0);
        check("isrc_xfer",   xfer_data, 32'h0000_1234);

        // Invalid destination code.
        req_valid = 1'b1; req_src = 5'd0; req_dst = 5'd30;
        tick();
        req_valid = 1'b0;
        check("idst_done", 32'(done), 32'd1);
        check("idst_err",  32'(err), 32'd1);
        check("idst_src",  32'(src_out), 32'h0);
        check("idst_dst",  32'(dst_in), 32'h0);
        tick();
        check("idst_ready", 32'(req_ready), 32'd1);

        // Back-to-back with req_valid held high and codes changing while busy.
        req_valid = 1'b1; req_src = 5'd1; req_dst = 5'd2; bus_in = 32'h0000_0011;
        tick();
        req_src = 5'd16; req_dst = 5'd7;
        check("bb1_src", 32'(src_out), 32'h0000_0002);
        check("bb1_dst", 32'(dst_in), 32'h0);
        tick();
        check("bb2_src", 32'(src_out), 32'h0000_0002);
        check("bb2_dst", 32'(dst_in), 32'h0000_0004);
        tick();
        bus_in = 32'h0000_0077;
        check("bb3_done",  32'(done), 32'd1);
        check("bb3_ready", 32'(req_ready), 32'd0);
        check("bb3_src",   32'(src_out), 32'h0);
        check("bb3_xfer",  xfer_data, 32'h0000_0011);
        tick();
        check("bb4_ready", 32'(req_ready), 32'd1);
        check("bb4_src",   32'(src_out), 32'h0);
        tick();
        req_valid = 1'b0; req_src = 5'd9; req_dst = 5'd9;
        check("bb5_src", 32'(src_out), 32'h0001_0000);
        check("bb5_dst", 32'(dst_in), 32'h0);
        tick();
        check("bb6_src", 32'(src_out), 32'h0001_0000);
        check("bb6_dst", 32'(dst_in), 32'h0000_0080);
        tick();
        check("bb7_done", 32'(done), 32'd1);
        check("bb7_xfer", xfer_data, 32'h0000_0077);
        tick();

        // Reset during CAPTURE of R5 -> R5, then a normal transfer.
        req_valid = 1'b1; req_src = 5'd5; req_dst = 5'd5; bus_in = 32'h0000_0055;
        tick();
        req_valid = 1'b0;
        tick();
        check("rm_cap_src", 32'(src_out), 32'h0000_0020);
        check("rm_cap_dst", 32'(dst_in), 32'h0000_0020);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("rm_src",  32'(src_out), 32'h0);
        check("rm_dst",  32'(dst_in), 32'h0);
        check("rm_done", 32'(done), 32'd0);
        check("rm_xfer", xfer_data, 32'h0);
        check("rm_ready", 32'(req_ready), 32'd1);
        tick();
        check("rm_done2", 32'(done), 32'd0);
        req_valid = 1'b1; req_src = 5'd23; req_dst = 5'd23; bus_in = 32'h0000_A5A5;
        tick();
        req_valid = 1'b0;
        check("ra1_src", 32'(src_out), 32'h0080_0000);
        tick();
        check("ra2_dst", 32'(dst_in), 32'h0080_0000);
        tick();
        check("ra3_done", 32'(done), 32'd1);
        check("ra3_err",  32'(err), 32'd0);
        check("ra3_xfer", xfer_data, 32'h0000_A5A5);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_xfer_seq.md
Name: bus_xfer_seq

Overview:
- Control-side sequencer for the datapath bus. It accepts a single transfer request naming one source and one destination.
- It drives exactly one one-hot source-enable strobe into the bus multiplexer's Xout select inputs, then pulses exactly one destination-enable strobe (Xin) while the source is still driven.
- It captures the bus value and reports completion.
- It sits between the control unit and the bus/register-file enables, so that only one source ever drives the bus.

Parameters:
- NSRC, 25, number of bus sources. Code index: 0-15 = R0-R15, 16 = LO, 17 = HI, 18 = Zhigh, 19 = Zlow, 20 = PC, 21 = MAR, 22 = MDR, 23 = InPort, 24 = C.
- NDST, 24, number of destination-enable lines; code index n maps to dst_in[n].
- SETTLE, 1, cycles spent in DRIVE before CAPTURE; minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- req_valid  in  1  transfer request present.
- req_ready  out  1  sequencer can accept a request.
- req_src  in  5  source code.
- req_dst  in  5  destination code; 5'h1F = no destination (drive-only).
- bus_in  in  32  BusMuxOut from the bus multiplexer.
- src_out  out  NSRC  one-hot source enables, bit n to the nth Xout input.
- dst_in  out  NDST  one-hot destination enables.
- xfer_data  out  32  bus value captured in CAPTURE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for a rejected request.

Behaviour:
- Reset (clr high at an edge):
  - State goes to IDLE and the settle counter goes to 0.
  - src_out, dst_in, done and err go to 0; xfer_data goes to 32'h0.
  - Reset overrides any operation in progress. On the edge where clr is sampled, all strobes drop and any transfer in flight is abandoned with no done.
- State machine: IDLE, DRIVE, CAPTURE, DONE.
- IDLE:
  - req_ready = 1 (combinational from state); all strobes 0.
  - A request is accepted on an edge with req_valid & req_ready. req_src and req_dst are registered at that edge.
  - A valid request moves to DRIVE with the settle counter = SETTLE-1.
  - An invalid request moves to DONE with err set. A request is invalid if req_src >= NSRC, or req_dst >= NDST and req_dst != 5'h1F.
- DRIVE:
  - src_out = 1 << src; dst_in = 0.
  - The counter decrements each cycle. When the counter = 0, go to CAPTURE.
- CAPTURE (exactly one cycle):
  - src_out is held.
  - dst_in = 1 << dst, or 0 when dst = 5'h1F.
  - xfer_data <= bus_in at the edge leaving CAPTURE.
  - Go to DONE.
- DONE (one cycle):
  - All strobes 0; done = 1; err = 1 only for a rejected request; req_ready = 0.
  - Go to IDLE.
- Latency with SETTLE = 1, accept edge at t0:
  - DRIVE during cycle 1, CAPTURE during cycle 2, done during cycle 3.
  - req_ready is high again in cycle 4.
  - Throughput: one transfer per SETTLE+3 cycles.
- Rejected request: accept edge t0, then DONE with err in cycle 1. No strobe is ever asserted.
- Invariants, checked every cycle:
  - popcount(src_out) <= 1 and popcount(dst_in) <= 1.
  - dst_in nonzero implies src_out nonzero.
  - Strobes change only on clock edges; outputs are registered or decoded from registered state, so they are glitch-free.
- Any req_valid while req_ready = 0 is ignored and not queued. req_src and req_dst may change freely after acceptance.
- Source equals destination register (e.g. R5 to R5) is legal: R5out and R5in are asserted together in CAPTURE.

Test Plan:
- Reset: drive clr for 2 cycles with req_valid = 1 -> req_ready = 1 after release; src_out, dst_in, done and err all 0; xfer_data = 0.
- Basic transfer, SETTLE = 1: req_src = 20 (PC), req_dst = 3, bus_in = 32'h0000_1234 -> src_out = 1 << 20 in cycles 1-2; dst_in = 1 << 3 in cycle 2 only; done in cycle 3; xfer_data = 32'h1234; err = 0.
- SETTLE = 3: req_src = 24 (C), req_dst = 5'h1F -> src_out = 1 << 24 for 4 cycles; dst_in stays 0 throughout; done in the 5th cycle after accept.
- Invalid codes:
  - req_src = 25 -> done and err high in cycle 1; src_out and dst_in never nonzero.
  - Repeat with req_src = 0, req_dst = 30 -> same response.
- Busy and back-to-back: hold req_valid high continuously with changing codes (src 1/dst 2, then src 16/dst 7) -> second request accepted only in IDLE after DONE; no overlapping strobes; the second transfer uses the codes present at its accept edge.
- Reset mid-transfer: assert clr during CAPTURE -> strobes 0 at the next edge; no done pulse; xfer_data = 0; next request completes normally.
